// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
//
// SPI mode-0 peripheral in front of a bank of NUM_REGS configuration registers
// of DATA_W bits each. A frame is sent MSB first as {rw, addr, data}, where
// rw = 1 means write and rw = 0 means read. Writes are committed when cs_n
// rises, and only if the frame is well formed. Reads return the addressed
// register on CIPO during the data phase of the same frame.
//
// All SPI pins are asynchronous to clk. They pass through a synchroniser and
// are oversampled, so clk must run at least 8x faster than sclk.
//
// Optional feature (compile-time macro SPI_STATUS_EN):
//   When defined, a read-only status register sits at address NUM_REGS. It
//   holds a saturating 8-bit count of discarded write frames. When the macro
//   is undefined, that address behaves like any other unimplemented address.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sclk       in   SPI clock (async, idle low)
//   cs_n       in   SPI chip select, active low (async)
//   copi       in   SPI controller-out data (async)
//   cipo       out  SPI peripheral-out data; 0 when not returning read data
//   cipo_oe    out  CIPO pad output enable, follows synchronised !cs_n
//   regs_flat  out  register contents, register k at [k*DATA_W +: DATA_W]
//   wr_strobe  out  one-clk pulse after each committed write
//   wr_addr    out  address of the last committed write
//
// Handshake: there is no valid/ready pair on this block. regs_flat is always
// valid. A commit updates regs_flat and wr_addr on the same clk edge that
// raises wr_strobe, and wr_strobe stays high for exactly one clk.
// -----------------------------------------------------------------------------
module spi_reg_bank #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int SH_W      = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam int AW1       = ADDR_W + 1;
    localparam int FL_W      = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0] CNT_ADDR   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_OVER   = CNT_W'(FRAME_LEN + 1);
    localparam logic [AW1-1:0]   NUM_REGS_X = AW1'(NUM_REGS);
    localparam logic [FL_W-1:0]  FLUSH_DONE = FL_W'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Input synchronisers. The reset values model an idle bus.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   sclk_hist_q;
    logic                   cs_hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, copi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s &  sclk_hist_q;
    assign cs_fall   = ~cs_s   &  cs_hist_q;
    assign cs_rise   =  cs_s   & ~cs_hist_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                         armed_q,     armed_d;
    logic                         rw_q,        rw_d;
    logic [CNT_W-1:0]             bit_cnt_q,   bit_cnt_d;
    logic [SH_W-1:0]              shift_q,     shift_d;
    logic [DATA_W-1:0]            rd_sh_q,     rd_sh_d;
    logic                         cipo_q,      cipo_d;
    logic [NUM_REGS*DATA_W-1:0]   regs_q,      regs_d;
    logic                         wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]            wr_addr_q,   wr_addr_d;
    logic [FL_W-1:0]              flush_q,     flush_d;
    logic                         idle_seen_q, idle_seen_d;

`ifdef SPI_STATUS_EN
    logic [7:0]                   err_cnt_q,   err_cnt_d;
`endif

    logic [SH_W-1:0]   shift_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              addr_in_range;
    logic              commit;

    // The rw bit is held in rw_q, so shift_q only collects {addr, data}.
    // Once the frame is exactly FRAME_LEN bits, shift_q holds {addr, data}.
    assign shift_next    = {shift_q[SH_W-2:0], copi_s};
    assign rd_addr       = shift_next[ADDR_W-1:0];
    assign frame_addr    = shift_q[DATA_W +: ADDR_W];
    assign frame_data    = shift_q[DATA_W-1:0];
    assign addr_in_range = ({1'b0, frame_addr} < NUM_REGS_X);

    // Readback mux. Unimplemented addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if ({1'b0, rd_addr} == AW1'(k)) begin
                rd_data = regs_q[k*DATA_W +: DATA_W];
            end
        end
`ifdef SPI_STATUS_EN
        if ({1'b0, rd_addr} == NUM_REGS_X) begin
            rd_data = DATA_W'(err_cnt_q);
        end
`endif
    end

    // After reset the synchronised cs_n reads high even if the pin is low.
    // A release with the pin low would therefore look like a cs_n fall in
    // the middle of a frame. Arming is held off until the pipeline has
    // flushed and cs_n has been seen genuinely high.
    always_comb begin
        flush_d     = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 1'b1;
        idle_seen_d = idle_seen_q | ((flush_q == FLUSH_DONE) & cs_s);
    end

    always_comb begin
        armed_d     = armed_q;
        rw_d        = rw_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rd_sh_d     = rd_sh_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        commit      = 1'b0;

        if (cs_fall && idle_seen_q) begin
            armed_d   = 1'b1;
            rw_d      = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
            rd_sh_d   = '0;
            cipo_d    = 1'b0;
        end else if (cs_rise) begin
            armed_d = 1'b0;
            rd_sh_d = '0;
            cipo_d  = 1'b0;
            commit  = armed_q && rw_q && (bit_cnt_q == CNT_FULL) && addr_in_range;
            if (commit) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (frame_addr == ADDR_W'(k)) begin
                        regs_d[k*DATA_W +: DATA_W] = frame_data;
                    end
                end
                wr_addr_d   = frame_addr;
                wr_strobe_d = 1'b1;
            end
        end else if (armed_q && !cs_s) begin
            if (sclk_rise && (bit_cnt_q != CNT_OVER)) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == '0) begin
                    rw_d = copi_s;
                end else begin
                    shift_d = shift_next;
                end
                // This sample completes the address field.
                if ((bit_cnt_q == CNT_ADDR) && !rw_q) begin
                    rd_sh_d = rd_data;
                end
            end else if (sclk_fall) begin
                // Zeros are shifted in behind the data, so cipo returns to 0
                // once the whole byte has gone out.
                cipo_d  = rd_sh_q[DATA_W-1];
                rd_sh_d = {rd_sh_q[DATA_W-2:0], 1'b0};
            end
        end
    end

`ifdef SPI_STATUS_EN
    // Counts every armed write frame that ends without a commit.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cs_rise && armed_q && rw_q && !commit && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            rw_q        <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rd_sh_q     <= '0;
            cipo_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            flush_q     <= '0;
            idle_seen_q <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            rw_q        <= rw_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_sh_q     <= rd_sh_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            flush_q     <= flush_d;
            idle_seen_q <= idle_seen_d;
        end
    end

    assign cipo      = cipo_q;
    assign cipo_oe   = ~cs_s;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank
//
// Bench for spi_reg_bank. An SPI controller task drives whole frames at a
// random sclk rate. The register bank, the error counter, the readback byte
// and the expected CIPO bit pattern are predicted from the frame contents
// alone. A compare process checks regs_flat, cipo_oe and the wr_strobe width
// on every cycle. Per-frame checks cover strobe count, wr_addr and CIPO bits.
// -----------------------------------------------------------------------------
module tb_spi_reg_bank;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 8;
    localparam int NUM_REGS    = 5;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_LEN   = 1 + ADDR_W + DATA_W;

    // ---------------- clock / reset / pins ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic copi  = 1'b0;
    logic cipo;
    logic cipo_oe;
    logic wr_strobe;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [ADDR_W-1:0]          wr_addr;

    always #5 clk = ~clk;

    spi_reg_bank #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    // ---------------- scoreboard / model ----------------
    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model_regs [NUM_REGS];
    logic [ADDR_W-1:0] model_wr_addr;
    int                model_err;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_read;
    logic              in_window    = 1'b0;
    int                strobe_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
        model_wr_addr = '0;
        model_err     = 0;
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = model_regs[k];
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] a);
        if (int'(a) < NUM_REGS) return model_regs[a];
`ifdef SPI_STATUS_EN
        if (int'(a) == NUM_REGS) return DATA_W'(model_err);
`endif
        return '0;
    endfunction

    // ---------------- per-cycle compare ----------------
    logic prev_strobe = 1'b0;
    logic prev_cs     = 1'b1;
    int   cs_stable   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cs_stable   = 0;
            prev_strobe = 1'b0;
        end else begin
            if (cs_n == prev_cs) cs_stable++;
            else cs_stable = 0;
            if (cs_stable > SYNC_STAGES + 2) check("cipo_oe", cipo_oe, !cs_n);
            if (wr_strobe) begin
                strobe_total++;
                check("strobe_width", prev_strobe, 1'b0);
            end
            prev_strobe = wr_strobe;
        end
        prev_cs = cs_n;
        if (!in_window) check("regs_flat", regs_flat, model_flat());
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the first n bits of f (extra bits beyond FRAME_LEN are random).
    task automatic send_frame(input logic [FRAME_LEN-1:0] f, input int n);
        int                half;
        int                s0;
        int                last;
        logic [63:0]       cap;
        logic [63:0]       expv;
        logic              rw;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] rb;
        logic [DATA_W-1:0] got;
        logic              do_commit;
        logic              do_read;

        rw        = f[FRAME_LEN-1];
        a         = f[DATA_W +: ADDR_W];
        d         = f[DATA_W-1:0];
        do_commit = (n == FRAME_LEN) && rw && (int'(a) < NUM_REGS);
        do_read   = !rw && (n >= 1 + ADDR_W);
        rb        = read_value(a);
        if (do_read) exp_q.push_back(rb);

        cap  = '0;
        s0   = strobe_total;
        half = $urandom_range(5, 8);

        cs_n = 1'b0;
        tick(half);
        for (int i = 1; i <= n; i++) begin
            copi = (i <= FRAME_LEN) ? f[FRAME_LEN-i] : 1'($urandom);
            tick(half);
            cap[i-1] = cipo;
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
        tick(half);

        in_window = 1'b1;
        cs_n = 1'b1;
        if (do_commit) begin
            model_regs[a] = d;
            model_wr_addr = a;
        end else if (rw && n >= 1) begin
            if (model_err < 255) model_err++;
        end
        tick(10);
        in_window = 1'b0;

        check("strobe_count", 64'(strobe_total - s0), 64'(do_commit));
        check("wr_addr", wr_addr, model_wr_addr);

        // Bit sampled on rise i is bit (FRAME_LEN-i) of the read byte.
        expv = '0;
        last = (n < FRAME_LEN) ? n : FRAME_LEN;
        if (do_read) begin
            for (int i = ADDR_W + 2; i <= last; i++) expv[i-1] = rb[FRAME_LEN-i];
        end
        check("cipo_bits", cap, expv);

        if (do_read) begin
            got = '0;
            for (int j = 0; j < DATA_W; j++) got[DATA_W-1-j] = cap[ADDR_W+1+j];
            if (n >= FRAME_LEN) check("read_byte", got, exp_q.pop_front());
            else void'(exp_q.pop_front());
            last_read = got;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0]    st_exp;
        logic [FRAME_LEN-1:0] f;
        logic [ADDR_W-1:0]    ra;
        int                   rn;
        int                   s0;

        model_reset();
        last_read = '0;
        rst_n = 1'b0;
        tick(4);
        check("rst_regs", regs_flat, '0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, '0);
        check("rst_cipo", cipo, 1'b0);
        check("rst_cipo_oe", cipo_oe, 1'b0);
        rst_n = 1'b1;
        tick(6);

        send_frame({1'b1, 7'd0, 8'hA5}, FRAME_LEN);
        check("reg0_lit", regs_flat[7:0], 8'hA5);
        check("wr_addr0_lit", wr_addr, 7'd0);

        send_frame({1'b1, 7'd4, 8'h3C}, FRAME_LEN);
        check("wr_addr4_lit", wr_addr, 7'd4);
        send_frame({1'b0, 7'd4, 8'h00}, FRAME_LEN);
        check("rd4_lit", last_read, 8'h3C);
        check("reg4_lit", regs_flat[39:32], 8'h3C);

        send_frame({1'b1, 7'd1, 8'hFF}, 12);
        send_frame({1'b1, 7'd1, 8'hFF}, 17);
        check("reg1_lit", regs_flat[15:8], 8'h00);

        send_frame({1'b1, 7'h7F, 8'h55}, FRAME_LEN);
        check("oor_regs_lit", regs_flat, 40'h3C_0000_00A5);
        send_frame({1'b0, 7'h7F, 8'h00}, FRAME_LEN);
        check("rd7f_lit", last_read, 8'h00);

        send_frame({1'b0, 7'd5, 8'h00}, FRAME_LEN);
`ifdef SPI_STATUS_EN
        st_exp = 8'h03;
`else
        st_exp = 8'h00;
`endif
        check("status_lit", last_read, st_exp);

        // Reset in the middle of a write to reg2, after 10 bits.
        f  = {1'b1, 7'd2, 8'h11};
        s0 = strobe_total;
        cs_n = 1'b0;
        tick(6);
        for (int i = 1; i <= 10; i++) begin
            copi = f[FRAME_LEN-i];
            tick(6);
            sclk = 1'b1;
            tick(6);
            sclk = 1'b0;
        end
        tick(3);
        rst_n = 1'b0;
        model_reset();
        tick(4);
        check("midrst_regs_lit", regs_flat, '0);
        check("midrst_cipo_oe", cipo_oe, 1'b0);
        rst_n = 1'b1;
        tick(6);
        cs_n = 1'b1;
        tick(12);
        check("midrst_no_strobe", 64'(strobe_total - s0), 64'd0);
        check("midrst_regs_after", regs_flat, '0);

        send_frame({1'b1, 7'd2, 8'h22}, FRAME_LEN);
        check("reg2_lit", regs_flat[23:16], 8'h22);
        check("wr_addr2_lit", wr_addr, 7'd2);

        // Randomised frames: mixed read/write, mostly legal addresses,
        // occasional bad lengths.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) < 7) ra = ADDR_W'($urandom_range(0, NUM_REGS));
            else ra = ADDR_W'($urandom);
            if ($urandom_range(0, 4) == 0) rn = $urandom_range(0, FRAME_LEN + 3);
            else rn = FRAME_LEN;
            send_frame({1'($urandom), ra, DATA_W'($urandom)}, rn);
        end

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
